// File: rtl/vga_timing_rx.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_rx
// Purpose  : Recovers active-area coordinates from an hsync/vsync/de stream
//            and measures the video mode, asserting locked once it is stable.
// Revision : 1.0
// ============================================================================
module vga_timing_rx #(
    parameter int CORDW       = 11,
    parameter bit HS_NEG      = 1'b1,
    parameter bit VS_NEG      = 1'b1,
    parameter int LOCK_FRAMES = 3,
    parameter int TIMEOUT     = 4095
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic             de_o,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             line,
    output logic             frame,
    output logic [CORDW-1:0] h_total,
    output logic [CORDW-1:0] h_active,
    output logic [CORDW-1:0] v_total,
    output logic [CORDW-1:0] v_active,
    output logic             locked,
    output logic             lock_lost
);

    localparam logic [CORDW-1:0] C_MAX         = '1;
    localparam int               C_TW          = $clog2(TIMEOUT + 2);
    localparam logic [C_TW-1:0]  C_TIMEOUT     = C_TW'(TIMEOUT);
    localparam logic [C_TW-1:0]  C_TSAT        = C_TW'(TIMEOUT + 1);
    localparam logic [3:0]       C_LOCK_FRAMES = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEED   = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v,
                                                 input logic en);
        return (en && (v != C_MAX)) ? v + CORDW'(1) : v;
    endfunction

    logic r_hs1, r_hs2, r_vs1, r_vs2, r_de1, r_de2;
    logic w_hs_start, w_vs_start, w_de_fall, w_timeout;

    logic [CORDW-1:0] r_hcnt, r_hact, r_vcnt, r_vact;
    logic [CORDW-1:0] r_m_htot, r_m_hact, r_m_vtot, r_m_vact;
    logic [CORDW-1:0] w_m_htot, w_m_hact, w_m_vtot, w_m_vact;
    logic [CORDW-1:0] r_ref_htot, r_ref_hact, r_ref_vtot, r_ref_vact;
    logic [C_TW-1:0]  r_tcnt;

    logic             r_de_o, r_line, r_frame, r_locked, r_lock_lost;
    logic [CORDW-1:0] r_sx, r_sy;

    state_t     r_state, w_state_next;
    logic [3:0] r_match, w_match_next, w_match_inc;
    logic       w_same, w_ref_load, w_ref_clr, w_lost;

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_hs1 <= 1'b0;
            r_hs2 <= 1'b0;
            r_vs1 <= 1'b0;
            r_vs2 <= 1'b0;
            r_de1 <= 1'b0;
            r_de2 <= 1'b0;
        end else begin
            r_hs1 <= hsync ^ HS_NEG;
            r_vs1 <= vsync ^ VS_NEG;
            r_de1 <= de;
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_de2 <= r_de1;
        end
    end

    assign w_hs_start = r_hs1 & ~r_hs2;
    assign w_vs_start = r_vs1 & ~r_vs2;
    assign w_de_fall  = ~r_de1 & r_de2;
    // Fires once per sync-less stretch; the counter parks one past TIMEOUT.
    assign w_timeout  = (r_tcnt == C_TIMEOUT) & ~w_hs_start;

    // Values the frame being closed by vs_start is judged on, including any
    // hs_start/de_fall landing on that same cycle.
    assign w_m_htot = w_hs_start ? sat_inc(r_hcnt, 1'b1) : r_m_htot;
    assign w_m_hact = w_de_fall  ? r_hact : r_m_hact;
    assign w_m_vtot = sat_inc(r_vcnt, w_hs_start);
    assign w_m_vact = sat_inc(r_vact, w_de_fall);

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_hcnt   <= '0;
            r_hact   <= '0;
            r_vcnt   <= '0;
            r_vact   <= '0;
            r_m_htot <= '0;
            r_m_hact <= '0;
            r_m_vtot <= '0;
            r_m_vact <= '0;
            r_tcnt   <= '0;
        end else begin
            if (w_hs_start) begin
                r_m_htot <= w_m_htot;
                r_hcnt   <= '0;
            end else begin
                r_hcnt   <= sat_inc(r_hcnt, 1'b1);
            end

            if (w_de_fall) begin
                r_m_hact <= r_hact;
                r_hact   <= '0;
            end else begin
                r_hact   <= sat_inc(r_hact, r_de1);
            end

            if (w_vs_start) begin
                r_m_vtot <= w_m_vtot;
                r_m_vact <= w_m_vact;
                r_vcnt   <= '0;
                r_vact   <= '0;
            end else begin
                r_vcnt   <= sat_inc(r_vcnt, w_hs_start);
                r_vact   <= sat_inc(r_vact, w_de_fall);
            end

            if (w_timeout) begin
                r_m_htot <= '0;
                r_m_hact <= '0;
                r_m_vtot <= '0;
                r_m_vact <= '0;
            end

            if (w_hs_start) begin
                r_tcnt <= '0;
            end else if (r_tcnt != C_TSAT) begin
                r_tcnt <= r_tcnt + C_TW'(1);
            end
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_de_o  <= 1'b0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_de_o  <= r_de1;
            r_line  <= w_de_fall;
            r_frame <= w_vs_start;

            if (w_timeout || !(r_de1 && r_de2)) begin
                r_sx <= '0;
            end else begin
                r_sx <= sat_inc(r_sx, 1'b1);
            end

            if (w_timeout || w_vs_start) begin
                r_sy <= '0;
            end else begin
                r_sy <= sat_inc(r_sy, w_de_fall);
            end
        end
    end

    assign w_same = (w_m_htot == r_ref_htot) && (w_m_hact == r_ref_hact) &&
                    (w_m_vtot == r_ref_vtot) && (w_m_vact == r_ref_vact);
    assign w_match_inc = r_match + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_match_next = r_match;
        w_ref_load   = 1'b0;
        w_ref_clr    = 1'b0;
        w_lost       = 1'b0;
        if (w_timeout) begin
            w_state_next = S_IDLE;
            w_match_next = 4'd0;
            w_ref_clr    = 1'b1;
            w_lost       = (r_state == S_LOCKED);
        end else if (w_vs_start) begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_SEED;
                end
                S_SEED: begin
                    w_ref_load   = 1'b1;
                    w_match_next = 4'd1;
                    w_state_next = (C_LOCK_FRAMES == 4'd1) ? S_LOCKED : S_TRACK;
                end
                S_TRACK: begin
                    if (w_same) begin
                        w_match_next = w_match_inc;
                        if (w_match_inc >= C_LOCK_FRAMES) begin
                            w_state_next = S_LOCKED;
                        end
                    end else begin
                        w_ref_load   = 1'b1;
                        w_match_next = 4'd1;
                    end
                end
                S_LOCKED: begin
                    if (!w_same) begin
                        w_ref_load   = 1'b1;
                        w_match_next = 4'd1;
                        w_state_next = S_TRACK;
                        w_lost       = 1'b1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_state     <= S_IDLE;
            r_match     <= 4'd0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_ref_htot  <= '0;
            r_ref_hact  <= '0;
            r_ref_vtot  <= '0;
            r_ref_vact  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_match     <= w_match_next;
            r_locked    <= (w_state_next == S_LOCKED);
            r_lock_lost <= w_lost;
            if (w_ref_clr) begin
                r_ref_htot <= '0;
                r_ref_hact <= '0;
                r_ref_vtot <= '0;
                r_ref_vact <= '0;
            end else if (w_ref_load) begin
                r_ref_htot <= w_m_htot;
                r_ref_hact <= w_m_hact;
                r_ref_vtot <= w_m_vtot;
                r_ref_vact <= w_m_vact;
            end
        end
    end

    assign de_o      = r_de_o;
    assign sx        = r_sx;
    assign sy        = r_sy;
    assign line      = r_line;
    assign frame     = r_frame;
    assign h_total   = r_ref_htot;
    assign h_active  = r_ref_hact;
    assign v_total   = r_ref_vtot;
    assign v_active  = r_ref_vact;
    assign locked    = r_locked;
    assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire
